// File: rtl/adder_pipelined.sv
// Pipelined ripple-carry add/sub: STAGES carry segments, one per register level after the input register.
// Result valid STAGES edges after acceptance; a waiting result freezes every level (in_ready = !stall).
module adder_pipelined #(
   parameter int WIDTH  = 111,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);

   localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

   // Number of result bits already produced once level k has been loaded.
   function automatic int done_bits(input int k);
      return (k * SEG < WIDTH) ? k * SEG : WIDTH;
   endfunction

   if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (STAGES - 1) * SEG >= WIDTH) begin : g_bad_params
      $error("adder_pipelined: WIDTH=%0d STAGES=%0d leaves an empty carry segment", WIDTH, STAGES);
   end

   logic stall;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k <= STAGES; k++) begin : g_lvl
      localparam int DK = done_bits(k);
      localparam int RK = WIDTH - DK;

      // d_q packs {b_remaining, a_remaining, result_so_far}; the last level holds only the result.
      logic [2*RK+DK-1:0] d_q;
      logic               c_q;
      logic               v_q;

      if (k == 0) begin : g_in
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (!stall) begin
               v_q <= in_valid;
               if (in_valid) begin
                  d_q <= {b ^ {WIDTH{sub}}, a};
                  c_q <= sub;
               end
            end
         end
      end else begin : g_seg
         localparam int DP = done_bits(k - 1);
         localparam int RP = WIDTH - DP;
         localparam int SW = DK - DP;

         logic [2*RP+DP-1:0] p;
         logic [2*RK+DK-1:0] nxt;
         logic               c_nxt;

         assign p = g_lvl[k-1].d_q;

         always_comb begin
            nxt   = '0;
            c_nxt = g_lvl[k-1].c_q;
            for (int i = 0; i < DP; i++) begin
               nxt[i] = p[i];
            end
            for (int i = 0; i < SW; i++) begin
               nxt[DP+i] = p[DP+i] ^ p[DP+RP+i] ^ c_nxt;
               c_nxt     = (p[DP+i] & p[DP+RP+i]) | (c_nxt & (p[DP+i] ^ p[DP+RP+i]));
            end
            // Unprocessed operand bits slide down to sit right above the finished result.
            for (int i = SW; i < RP; i++) begin
               nxt[DK+i-SW]    = p[DP+i];
               nxt[DK+RK+i-SW] = p[DP+RP+i];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d_q <= '0;
               c_q <= 1'b0;
               v_q <= 1'b0;
            end else if (!stall) begin
               d_q <= nxt;
               c_q <= c_nxt;
               v_q <= g_lvl[k-1].v_q;
            end
         end

         if (k == STAGES) begin : g_flag
            // Carry into the MSB recovered from its sum bit: cin = s ^ a ^ b.
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  ovf <= 1'b0;
               end else if (!stall) begin
                  ovf <= nxt[WIDTH-1] ^ p[DP+RP-1] ^ p[2*RP+DP-1] ^ c_nxt;
               end
            end
         end
      end
   end

   assign out_valid = g_lvl[STAGES].v_q;
   assign sum       = {g_lvl[STAGES].c_q, g_lvl[STAGES].d_q};

endmodule

// File: tb/tb_adder_pipelined.sv
// Bench for adder_pipelined: directed cases, stall/backpressure, reset and parameter corners vs. an arithmetic model.
module tb_adder_pipelined;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic         m_in_valid, m_in_ready, m_sub, m_out_valid, m_out_ready, m_ovf;
   logic [110:0] m_a, m_b;
   logic [111:0] m_sum;

   logic       c1_in_valid, c1_in_ready, c1_sub, c1_out_valid, c1_out_ready, c1_ovf;
   logic [7:0] c1_a, c1_b;
   logic [8:0] c1_sum;
   logic       c8_in_valid, c8_in_ready, c8_sub, c8_out_valid, c8_out_ready, c8_ovf;
   logic [7:0] c8_a, c8_b;
   logic [8:0] c8_sum;
   logic       c3_in_valid, c3_in_ready, c3_sub, c3_out_valid, c3_out_ready, c3_ovf;
   logic [7:0] c3_a, c3_b;
   logic [8:0] c3_sum;

   adder_pipelined #(.WIDTH(111), .STAGES(4)) u_main (
      .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .a(m_a), .b(m_b), .sub(m_sub), .out_valid(m_out_valid), .out_ready(m_out_ready),
      .sum(m_sum), .ovf(m_ovf));

   adder_pipelined #(.WIDTH(8), .STAGES(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
      .a(c1_a), .b(c1_b), .sub(c1_sub), .out_valid(c1_out_valid), .out_ready(c1_out_ready),
      .sum(c1_sum), .ovf(c1_ovf));

   adder_pipelined #(.WIDTH(8), .STAGES(8)) u_c8 (
      .clk(clk), .rst_n(rst_n), .in_valid(c8_in_valid), .in_ready(c8_in_ready),
      .a(c8_a), .b(c8_b), .sub(c8_sub), .out_valid(c8_out_valid), .out_ready(c8_out_ready),
      .sum(c8_sum), .ovf(c8_ovf));

   adder_pipelined #(.WIDTH(8), .STAGES(3)) u_c3 (
      .clk(clk), .rst_n(rst_n), .in_valid(c3_in_valid), .in_ready(c3_in_ready),
      .a(c3_a), .b(c3_b), .sub(c3_sub), .out_valid(c3_out_valid), .out_ready(c3_out_ready),
      .sum(c3_sum), .ovf(c3_ovf));

   // Reference: plain integer arithmetic; bit w of the result is the carry (no-borrow for subtraction).
   function automatic logic [127:0] ref_sum(input int w, input logic [127:0] x, input logic [127:0] y, input bit s);
      return s ? (x + (128'd1 << w) - y) : (x + y);
   endfunction

   // Signed overflow: the true signed result does not fit, seen as a wrong result sign.
   function automatic bit ref_ovf(input int w, input logic [127:0] x, input logic [127:0] y, input bit s);
      logic [127:0] r;
      bit sx, sy, sr;
      r  = ref_sum(w, x, y, s);
      sx = x[w-1];
      sy = y[w-1];
      sr = r[w-1];
      return s ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
   endfunction

   function automatic logic [110:0] rnd111();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[110:0];
   endfunction

   task automatic idle(input int n);
      m_in_valid  = 1'b0;
      m_out_ready = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic main_op(input logic [110:0] x, input logic [110:0] y, input logic s,
                          output logic [111:0] rs, output logic ro, output int lat);
      m_a = x; m_b = y; m_sub = s; m_in_valid = 1'b1; m_out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_in_valid = 1'b0;
      lat = -1; rs = '0; ro = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (m_out_valid) begin
            lat = n; rs = m_sum; ro = m_ovf;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_in_valid = 1'b0; m_a = '0; m_b = '0; m_sub = 1'b0; m_out_ready = 1'b1;
      c1_in_valid = 1'b0; c1_a = '0; c1_b = '0; c1_sub = 1'b0; c1_out_ready = 1'b1;
      c8_in_valid = 1'b0; c8_a = '0; c8_b = '0; c8_sub = 1'b0; c8_out_ready = 1'b1;
      c3_in_valid = 1'b0; c3_a = '0; c3_b = '0; c3_sub = 1'b0; c3_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (m_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", m_out_valid); else passed++;
      checks++; if (m_sum !== 112'd0) $display("FAIL reset_sum: got %h want 0", m_sum); else passed++;
      checks++; if (m_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", m_ovf); else passed++;
      checks++; if (m_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", m_in_ready); else passed++;
      checks++; if ({c1_out_valid, c8_out_valid, c3_out_valid} !== 3'b000)
         $display("FAIL reset_corner_valid: got %b want 000", {c1_out_valid, c8_out_valid, c3_out_valid}); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      // Accepted at the first edge after reset release (edge 0).
      m_a = 111'd1; m_b = 111'd2; m_sub = 1'b0; m_in_valid = 1'b1; m_out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_in_valid = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         @(posedge clk);
         #1;
         checks++;
         if (m_out_valid !== 1'b0 || m_sum !== 112'd0)
            $display("FAIL latency_early edge %0d: valid=%b sum=%h want valid=0 sum=0", n, m_out_valid, m_sum);
         else passed++;
      end
      @(posedge clk);
      #1;
      checks++; if (m_out_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", m_out_valid); else passed++;
      checks++; if (m_sum !== 112'd3) $display("FAIL latency_sum: got %h want 3", m_sum); else passed++;
      checks++; if (m_ovf !== 1'b0) $display("FAIL latency_ovf: got %b want 0", m_ovf); else passed++;
   endtask

   task automatic test_carry();
      logic [111:0] rs;
      logic         ro;
      int           lat;
      idle(6);
      main_op({111{1'b1}}, 111'd1, 1'b0, rs, ro, lat);
      checks++; if (lat != 4) $display("FAIL carry_full_latency: got %0d want 4", lat); else passed++;
      checks++; if (rs !== (112'd1 << 111) || ro !== 1'b0)
         $display("FAIL carry_full: sum=%h ovf=%b want %h ovf=0", rs, ro, 112'd1 << 111); else passed++;
      idle(6);
      main_op(111'((128'd1 << 28) - 128'd1), 111'd1, 1'b0, rs, ro, lat);
      checks++; if (rs !== (112'd1 << 28) || ro !== 1'b0)
         $display("FAIL carry_seg0: sum=%h ovf=%b want %h ovf=0", rs, ro, 112'd1 << 28); else passed++;
   endtask

   task automatic test_sub_ovf();
      logic [111:0] rs;
      logic         ro;
      int           lat;
      logic [127:0] e;
      logic [110:0] x;
      idle(6);
      main_op(111'd5, 111'd7, 1'b1, rs, ro, lat);
      checks++; if (rs[110:0] !== ~111'd1) $display("FAIL sub_borrow_value: got %h want %h", rs[110:0], ~111'd1); else passed++;
      checks++; if (rs[111] !== 1'b0) $display("FAIL sub_borrow_carry: got %b want 0", rs[111]); else passed++;
      idle(6);
      x = 111'd1 << 110;
      e = ref_sum(111, 128'(x), 128'd1, 1'b1);
      main_op(x, 111'd1, 1'b1, rs, ro, lat);
      checks++; if (ro !== 1'b1) $display("FAIL sub_ovf_flag: got %b want 1", ro); else passed++;
      checks++; if (rs !== e[111:0]) $display("FAIL sub_ovf_sum: got %h want %h", rs, e[111:0]); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] eq[$];
      bit           oq[$];
      logic [127:0] e;
      bit           eo;
      int           sent = 0, got = 0, stall_left = 3, stall_seen = 0;
      bit           started = 1'b0, need = 1'b1;
      idle(6);
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         if (m_out_valid) started = 1'b1;
         if (started && stall_left > 0) begin
            m_out_ready = 1'b0;
            stall_left--;
         end else begin
            m_out_ready = 1'b1;
         end
         if (sent < 10) begin
            if (need) begin
               m_a = rnd111(); m_b = rnd111(); m_sub = 1'($urandom_range(0, 1)); need = 1'b0;
            end
            m_in_valid = 1'b1;
         end else begin
            m_in_valid = 1'b0;
         end
         #1;
         checks++;
         if (m_in_ready !== !(m_out_valid && !m_out_ready))
            $display("FAIL b2b_in_ready cycle %0d: got %b want %b", cyc, m_in_ready, !(m_out_valid && !m_out_ready));
         else passed++;
         if (!m_in_ready) stall_seen++;
         if (m_out_valid && m_out_ready) begin
            checks++;
            if (eq.size() == 0) begin
               $display("FAIL b2b_extra_result: got %h with nothing outstanding", m_sum);
            end else begin
               e = eq.pop_front(); eo = oq.pop_front();
               if (m_sum !== e[111:0] || m_ovf !== eo)
                  $display("FAIL b2b_result %0d: sum=%h ovf=%b want %h ovf=%b", got, m_sum, m_ovf, e[111:0], eo);
               else passed++;
            end
            got++;
         end
         if (m_in_valid && m_in_ready) begin
            eq.push_back(ref_sum(111, 128'(m_a), 128'(m_b), m_sub));
            oq.push_back(ref_ovf(111, 128'(m_a), 128'(m_b), m_sub));
            sent++;
            need = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      m_in_valid = 1'b0;
      checks++; if (got != 10) $display("FAIL b2b_count: got %0d results want 10", got); else passed++;
      checks++; if (stall_seen != 3) $display("FAIL b2b_stall_cycles: got %0d want 3", stall_seen); else passed++;
   endtask

   task automatic test_reset_midflight();
      bit seen = 1'b0;
      idle(6);
      for (int i = 0; i < 3; i++) begin
         m_a = rnd111(); m_b = rnd111(); m_sub = 1'b0; m_in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      m_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (m_out_valid !== 1'b0 || m_sum !== 112'd0)
         $display("FAIL midflight_reset: valid=%b sum=%h want 0/0", m_out_valid, m_sum); else passed++;
      #1 rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
         @(posedge clk);
         #1;
         if (m_out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) $display("FAIL midflight_ghost: got out_valid=1 want none"); else passed++;

      // A result parked at the output by backpressure must vanish the moment reset asserts.
      m_a = 111'd3; m_b = 111'd4; m_sub = 1'b0; m_in_valid = 1'b1; m_out_ready = 1'b0;
      @(posedge clk);
      #1;
      m_in_valid = 1'b0;
      for (int n = 0; n < 10 && !m_out_valid; n++) begin
         @(posedge clk);
         #1;
      end
      checks++; if (m_out_valid !== 1'b1 || m_sum !== 112'd7)
         $display("FAIL parked_result: valid=%b sum=%h want 1/7", m_out_valid, m_sum); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (m_out_valid !== 1'b0 || m_sum !== 112'd0 || m_in_ready !== 1'b1)
         $display("FAIL parked_reset: valid=%b sum=%h in_ready=%b want 0/0/1", m_out_valid, m_sum, m_in_ready);
      else passed++;
      #1 rst_n = 1'b1;
      m_out_ready = 1'b1;
   endtask

   task automatic test_corners();
      int         lat;
      logic [8:0] s;
      logic       o;
      c1_a = 8'd255; c1_b = 8'd1; c1_sub = 1'b0; c1_in_valid = 1'b1; c1_out_ready = 1'b1;
      @(posedge clk);
      #1;
      c1_in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (c1_out_valid !== 1'b1 || c1_sum !== 9'h100 || c1_ovf !== 1'b0)
         $display("FAIL c1_carry: valid=%b sum=%h ovf=%b want 1/100/0", c1_out_valid, c1_sum, c1_ovf); else passed++;

      c8_a = 8'h7F; c8_b = 8'd1; c8_sub = 1'b0; c8_in_valid = 1'b1; c8_out_ready = 1'b1;
      @(posedge clk);
      #1;
      c8_in_valid = 1'b0;
      lat = -1; s = '0; o = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (c8_out_valid) begin
            lat = n; s = c8_sum; o = c8_ovf;
            break;
         end
      end
      checks++; if (lat != 8) $display("FAIL c8_latency: got %0d want 8", lat); else passed++;
      checks++; if (s !== 9'h080 || o !== 1'b1) $display("FAIL c8_ovf: sum=%h ovf=%b want 080/1", s, o); else passed++;
   endtask

   task automatic test_c3_random();
      logic [127:0] eq[$];
      bit           oq[$];
      logic [127:0] e;
      bit           eo;
      int           sent = 0, got = 0;
      bit           need = 1'b1;
      for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
         c3_out_ready = ($urandom_range(0, 3) != 0);
         if (sent < 300 && $urandom_range(0, 4) != 0) begin
            if (need) begin
               c3_a = 8'($urandom_range(0, 255)); c3_b = 8'($urandom_range(0, 255));
               c3_sub = 1'($urandom_range(0, 1)); need = 1'b0;
            end
            c3_in_valid = 1'b1;
         end else begin
            c3_in_valid = 1'b0;
         end
         #1;
         if (c3_out_valid && c3_out_ready) begin
            checks++;
            if (eq.size() == 0) begin
               $display("FAIL c3_extra_result: got %h with nothing outstanding", c3_sum);
            end else begin
               e = eq.pop_front(); eo = oq.pop_front();
               if (c3_sum !== e[8:0] || c3_ovf !== eo)
                  $display("FAIL c3_result %0d: sum=%h ovf=%b want %h ovf=%b", got, c3_sum, c3_ovf, e[8:0], eo);
               else passed++;
            end
            got++;
         end
         if (c3_in_valid && c3_in_ready) begin
            eq.push_back(ref_sum(8, 128'(c3_a), 128'(c3_b), c3_sub));
            oq.push_back(ref_ovf(8, 128'(c3_a), 128'(c3_b), c3_sub));
            sent++;
            need = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      c3_in_valid = 1'b0;
      c3_out_ready = 1'b1;
      checks++; if (got != 300) $display("FAIL c3_count: got %0d results want 300", got); else passed++;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_carry();
      test_sub_ovf();
      test_back_to_back();
      test_reset_midflight();
      test_corners();
      test_c3_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
